// File: rtl/div_pkg.sv
// Shared FSM encodings and handshake constants for the multi-cycle divider.
package div_pkg;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit and trial-subtract the divisor.
module div_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] rem,
    input  logic [DATA_W-1:0] quo,
    input  logic [DATA_W-1:0] dvs,
    output logic [DATA_W-1:0] rem_nxt,
    output logic [DATA_W-1:0] quo_nxt
);

    logic [DATA_W:0] shifted;
    logic            fits;

    assign shifted = {rem, quo[DATA_W-1]};
    assign fits    = (shifted >= {1'b0, dvs});
    // When the divisor fits, the true difference is below 2^DATA_W, so a wrapping subtract is exact.
    assign rem_nxt = fits ? (shifted[DATA_W-1:0] - dvs) : shifted[DATA_W-1:0];
    assign quo_nxt = {quo[DATA_W-2:0], fits};

endmodule

// File: rtl/div.sv
// Multi-cycle signed/unsigned restoring divider with annul and stall handshake for the EX stage.
module div
    import div_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o,
    output logic                  stallreq_o
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] v);
        return ~v + DATA_W'(1);
    endfunction

    function automatic logic [DATA_W-1:0] magnitude(input logic signed [DATA_W-1:0] v,
                                                    input logic                     is_signed);
        logic [DATA_W-1:0] m;
        m = v;
        if (is_signed && v[DATA_W-1])
            m = negate(m);
        return m;
    endfunction

    function automatic logic [DATA_W-1:0] apply_sign(input logic [DATA_W-1:0] v,
                                                     input logic              neg);
        return neg ? negate(v) : v;
    endfunction

    div_state_e state, state_nxt;

    logic signed [DATA_W-1:0] op1_s;
    logic signed [DATA_W-1:0] op2_s;

    logic [DATA_W-1:0] rem_p0;
    logic [DATA_W-1:0] quo_p0;
    logic [DATA_W-1:0] dvs_p0;
    logic              neg_quo_p0;
    logic              neg_rem_p0;
    logic [CNT_W-1:0]  cnt_p0;

    logic [DATA_W-1:0] rem_nxt;
    logic [DATA_W-1:0] quo_nxt;

    logic latch_en;
    logic step_en;
    logic finish_en;
    logic byzero_en;
    logic release_en;
    logic cnt_done;

    assign op1_s    = opdata1_i;
    assign op2_s    = opdata2_i;
    assign cnt_done = (cnt_p0 == CNT_W'(DATA_W));

    div_step #(
        .DATA_W (DATA_W)
    ) u_step (
        .rem     (rem_p0),
        .quo     (quo_p0),
        .dvs     (dvs_p0),
        .rem_nxt (rem_nxt),
        .quo_nxt (quo_nxt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= DivFree;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            DivFree: begin
                if (start_i == DivStart && !annul_i)
                    state_nxt = (opdata2_i == '0) ? DivByZero : DivOn;
            end
            DivByZero: state_nxt = DivEnd;
            DivOn: begin
                if (annul_i)
                    state_nxt = DivFree;
                else if (cnt_done)
                    state_nxt = DivEnd;
            end
            DivEnd: begin
                if (start_i == DivStop)
                    state_nxt = DivFree;
            end
            default: state_nxt = DivFree;
        endcase
    end

    always_comb begin
        latch_en   = 1'b0;
        step_en    = 1'b0;
        finish_en  = 1'b0;
        byzero_en  = 1'b0;
        release_en = 1'b0;
        case (state)
            DivFree:   latch_en   = (start_i == DivStart) && !annul_i;
            DivByZero: byzero_en  = 1'b1;
            DivOn: begin
                step_en   = !annul_i && !cnt_done;
                finish_en = !annul_i && cnt_done;
            end
            DivEnd:    release_en = (start_i == DivStop);
            default: ;
        endcase
        stallreq_o = start_i & ~annul_i & ~ready_o;
    end

    // Stage p0: operand capture and one quotient bit per cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem_p0     <= '0;
            quo_p0     <= '0;
            dvs_p0     <= '0;
            neg_quo_p0 <= 1'b0;
            neg_rem_p0 <= 1'b0;
            cnt_p0     <= '0;
        end else if (latch_en) begin
            rem_p0     <= '0;
            quo_p0     <= magnitude(op1_s, signed_div_i);
            dvs_p0     <= magnitude(op2_s, signed_div_i);
            neg_quo_p0 <= signed_div_i & (op1_s[DATA_W-1] ^ op2_s[DATA_W-1]);
            neg_rem_p0 <= signed_div_i & op1_s[DATA_W-1];
            cnt_p0     <= '0;
        end else if (step_en) begin
            rem_p0     <= rem_nxt;
            quo_p0     <= quo_nxt;
            cnt_p0     <= cnt_p0 + CNT_W'(1);
        end
    end

    // Stage p1: sign fix-up into the registered result
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result_o <= '0;
            ready_o  <= DivResultNotReady;
        end else if (finish_en) begin
            result_o <= {apply_sign(rem_p0, neg_rem_p0), apply_sign(quo_p0, neg_quo_p0)};
            ready_o  <= DivResultReady;
        end else if (byzero_en) begin
            result_o <= '0;
            ready_o  <= DivResultReady;
        end else if (release_en) begin
            result_o <= '0;
            ready_o  <= DivResultNotReady;
        end
    end

endmodule

// File: tb/tb_div.sv
// Randomized self-checking bench for div against an arithmetic reference model.
module tb_div;

    logic        clk;
    logic        rst;
    logic        signed_div;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;
    logic        stallreq;

    int n_checks;
    int n_pass;

    div #(.DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (op1),
        .opdata2_i    (op2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready),
        .stallreq_o   (stallreq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference: plain truncating division; zero divisor yields all zeros.
    function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0)
            return 64'd0;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            return {r[31:0], q[31:0]};
        end
        return {a % b, a / b};
    endfunction

    task automatic run_div(input string tag, input logic s, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp);
        int lat;
        bit stall_ok;
        int exp_lat;
        exp_lat  = (b == 32'd0) ? 2 : 34;
        lat      = 0;
        stall_ok = 1'b1;
        @(negedge clk);
        signed_div = s; op1 = a; op2 = b; start = 1'b1; annul = 1'b0;
        #1;
        if (!stallreq) stall_ok = 1'b0;
        for (int e = 1; e <= 50; e++) begin
            @(posedge clk);
            #1;
            op1 = $urandom; op2 = $urandom; signed_div = $urandom_range(0, 1);
            if (ready) begin
                lat = e;
                break;
            end
            if (!stallreq) stall_ok = 1'b0;
        end
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_stall_before"}, 64'(stall_ok), 64'd1);
        check({tag, "_result"}, result, exp);
        check({tag, "_stall_end"}, 64'(stallreq), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        check({tag, "_hold"}, {ready, result[62:0]}, {1'b1, exp[62:0]});
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_release"}, {63'd0, ready} | result, 64'd0);
    endtask

    initial begin
        bit          rose;
        logic [31:0] a, b;
        logic        s;
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b0; start = 1'b0; annul = 1'b0; signed_div = 1'b0; op1 = '0; op2 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", 64'(ready), 64'd0);
        check("reset_result", result, 64'd0);
        check("reset_stall", 64'(stallreq), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        run_div("u100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E);
        run_div("s-7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD);
        run_div("u5_0", 1'b0, 32'd5, 32'd0, 64'd0);
        run_div("s_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);
        run_div("u_max_1", 1'b0, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF);
        run_div("u_min_m1", 1'b0, 32'h80000000, 32'hFFFFFFFF, 64'h80000000_00000000);

        // Annul after ten iterations
        @(negedge clk);
        signed_div = 1'b0; op1 = 32'd50; op2 = 32'd7; start = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        annul = 1'b1;
        #1;
        check("annul_stall", 64'(stallreq), 64'd0);
        @(posedge clk);
        #1;
        check("annul_ready", 64'(ready), 64'd0);
        @(negedge clk);
        start = 1'b0; annul = 1'b0;
        rose = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ready) rose = 1'b1;
        end
        check("annul_never_ready", 64'(rose), 64'd0);
        run_div("u9_3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003);

        // Asynchronous reset mid-iteration
        @(negedge clk);
        signed_div = 1'b0; op1 = 32'd1000; op2 = 32'd7; start = 1'b1;
        @(posedge clk);
        repeat (15) @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0; start = 1'b0;
        #1;
        check("rst_on_out", {63'd0, ready} | result, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        run_div("u20_6", 1'b0, 32'd20, 32'd6, 64'h00000002_00000003);

        // Asynchronous reset while a result is being held
        @(negedge clk);
        signed_div = 1'b0; op1 = 32'd77; op2 = 32'd5; start = 1'b1;
        rose = 1'b0;
        for (int e = 0; e < 50; e++) begin
            @(posedge clk);
            #1;
            if (ready) begin
                rose = 1'b1;
                break;
            end
        end
        check("rst_end_pre", {ready, result[62:0]}, {1'b1, 63'h00000002_0000000F});
        @(negedge clk);
        #2;
        rst = 1'b0; start = 1'b0;
        #1;
        check("rst_end_ready", 64'(ready), 64'd0);
        check("rst_end_result", result, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 30; i++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'hFFFFFFFF;
                3:       begin a = 32'h80000000; b = $urandom; end
                default: b = $urandom;
            endcase
            run_div("rnd", s, a, b, model(s, a, b));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
